rvco_meas_ctrl: RTL

- Digital sequencer for the two on-chip 11-stage ring VCOs.
- Per oscillator, in order: drives its reset, waits for settling, counts its output edges over a programmable gate window of clk cycles, and latches the count.
- Results are held per oscillator and read out byte-wise on uo_out; control arrives on ui_in/uio_in.

---
 rtl/rvco_pkg.sv | 23 ++
 rtl/rvco_edge_sync.sv | 18 +
 rtl/rvco_meas_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/rvco_pkg.sv
// Shared types and default parameters for the ring-VCO measurement sequencer.
package rvco_pkg;

  localparam int DEF_CNT_W      = 16;
  localparam int DEF_RST_CYC    = 16;
  localparam int DEF_SETTLE_CYC = 64;
  localparam int DEF_GATE_BASE  = 256;

  localparam logic [1:0] BSEL_RES0_LO = 2'd0;
  localparam logic [1:0] BSEL_RES0_HI = 2'd1;
  localparam logic [1:0] BSEL_RES1_LO = 2'd2;
  localparam logic [1:0] BSEL_RES1_HI = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    RST,
    SETTLE,
    GATE,
    LATCH,
    DONE
  } state_t;

endpackage

// File: rtl/rvco_edge_sync.sv
// Two-flop synchroniser followed by a rising-edge detector on the third flop.
module rvco_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d_async,
  output logic rise_pulse
);

  logic [2:0] sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sh <= 3'b000;
    else        sh <= {sh[1:0], d_async};
  end

  assign rise_pulse = sh[1] & ~sh[2];

endmodule

// File: rtl/rvco_meas_ctrl.sv
// Sequencer for the two ring VCOs: reset, settle, gated edge count, latch,
// with byte-wise readout of the per-oscillator results.
module rvco_meas_ctrl
  import rvco_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int RST_CYC    = DEF_RST_CYC,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int GATE_BASE  = DEF_GATE_BASE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       start,
  input  logic       cont,
  input  logic       alt,
  input  logic       osc_sel,
  input  logic [1:0] gate_sel,
  input  logic [1:0] osc_in,
  input  logic [1:0] byte_sel,
  output logic [1:0] osc_rst,
  output logic       busy,
  output logic       done,
  output logic       cur_osc,
  output logic [7:0] data_out
);

  state_t             state, next_state;
  logic [15:0]        cyc;
  logic [15:0]        gate_len;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   res0, res1;
  logic [1:0]         osc_rise;
  logic               start_rise;
  logic               sel_next;
  logic [15:0]        res0_w, res1_w;

  rvco_edge_sync u_sync_start (.clk(clk), .rst_n(rst_n), .d_async(start),     .rise_pulse(start_rise));
  rvco_edge_sync u_sync_osc0  (.clk(clk), .rst_n(rst_n), .d_async(osc_in[0]), .rise_pulse(osc_rise[0]));
  rvco_edge_sync u_sync_osc1  (.clk(clk), .rst_n(rst_n), .d_async(osc_in[1]), .rise_pulse(osc_rise[1]));

  assign sel_next = alt ? ~cur_osc : osc_sel;

  always_comb begin
    next_state = state;
    osc_rst    = 2'b11;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE:   if (start_rise) next_state = RST;
      RST: begin
        busy = 1'b1;
        if (cyc == 16'(RST_CYC - 1)) next_state = SETTLE;
      end
      SETTLE: begin
        busy             = 1'b1;
        osc_rst[cur_osc] = 1'b0;
        if (cyc == 16'(SETTLE_CYC - 1)) next_state = GATE;
      end
      GATE: begin
        busy             = 1'b1;
        osc_rst[cur_osc] = 1'b0;
        if (cyc == gate_len - 16'd1) next_state = LATCH;
      end
      LATCH: begin
        busy             = 1'b1;
        osc_rst[cur_osc] = 1'b0;
        done             = ena;
        next_state       = DONE;
      end
      DONE: begin
        osc_rst[cur_osc] = 1'b0;
        if (cont || start_rise) next_state = RST;
      end
      default: next_state = IDLE;
    endcase
    if (!ena) next_state = IDLE;
  end

  // Phase timer restarts on every state change; the gate length is frozen on GATE entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cyc      <= 16'd0;
      gate_len <= 16'd0;
      cur_osc  <= 1'b0;
    end else begin
      state <= next_state;
      if (next_state != state) cyc <= 16'd0;
      else                     cyc <= cyc + 16'd1;
      if (next_state == GATE && state != GATE)
        gate_len <= 16'(GATE_BASE) << gate_sel;
      if ((state == IDLE || state == DONE) && next_state == RST)
        cur_osc <= sel_next;
    end
  end

  // Saturating edge counter; results only update on a LATCH that was not aborted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      res0 <= '0;
      res1 <= '0;
    end else begin
      if (state == SETTLE && next_state == GATE)
        cnt <= '0;
      else if (state == GATE && osc_rise[cur_osc] && cnt != '1)
        cnt <= cnt + CNT_W'(1);
      if (state == LATCH && ena) begin
        if (cur_osc) res1 <= cnt;
        else         res0 <= cnt;
      end
    end
  end

  assign res0_w = 16'(res0);
  assign res1_w = 16'(res1);

  always_comb begin
    data_out = 8'h00;
    case (byte_sel)
      BSEL_RES0_LO: data_out = res0_w[7:0];
      BSEL_RES0_HI: data_out = res0_w[15:8];
      BSEL_RES1_LO: data_out = res1_w[7:0];
      BSEL_RES1_HI: data_out = res1_w[15:8];
      default:      data_out = 8'h00;
    endcase
  end

endmodule
